// File: rtl/rep_sequencer_ex.sv
// rep_sequencer_ex: REP / REPE / REPNE string-op sequencer.
// Owns the ECX/CX count register. Issues one micro-iteration at a time to WB,
// decrements the count after each completed iteration, evaluates termination,
// stalls EX while a sequence is in flight and writes the final count back.
// Optional feature macro: REP_ADDR16_EN. When defined, an addr16 input selects
// 16-bit counting, which uses only count[15:0] for the decrement and zero test.
module rep_sequencer_ex #(
    parameter int CNT_W  = 32,
    parameter int ZF_BIT = 6
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EX_V,
    input  logic             rep_start,
    input  logic [1:0]       rep_mode,
    input  logic [CNT_W-1:0] count_in,
    input  logic             wb_stall,
    input  logic             iter_done,
    input  logic [31:0]      flags_in,
    input  logic             flush,
`ifdef REP_ADDR16_EN
    input  logic             addr16,
`endif
    output logic             iter_v,
    output logic             busy,
    output logic             ex_stall,
    output logic [CNT_W-1:0] count_out,
    output logic             ld_count,
    output logic             done,
    output logic             terminated_early
);

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_REPE  = 2'b10;
    localparam logic [1:0] MODE_REPNE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [1:0]         mode_q;
    logic               early_q;

    logic               startReq;
    logic               startZero;
    logic [CNT_W-1:0]   count_d;
    logic               decZero;
    logic               zfTerm;
    logic               unusedFlags;

`ifdef REP_ADDR16_EN
    localparam logic [CNT_W-1:0] LO_MASK = CNT_W'(32'h0000_FFFF);
    logic               addr16_q;
`endif

    assign unusedFlags = ^flags_in;

    // Decode the start request and compute the decremented count and termination terms.
    always_comb begin
        startReq  = (state_q == S_IDLE) && EX_V && rep_start && (rep_mode != MODE_NONE);
        startZero = (count_in == '0);
        count_d   = count_q - CNT_W'(1);
        decZero   = (count_d == '0);
`ifdef REP_ADDR16_EN
        if (addr16) begin
            startZero = (count_in[15:0] == 16'd0);
        end
        if (addr16_q) begin
            count_d = (count_q & ~LO_MASK) | CNT_W'(count_q[15:0] - 16'd1);
            decZero = (count_d[15:0] == 16'd0);
        end
`endif
        zfTerm = ((mode_q == MODE_REPE)  && !flags_in[ZF_BIT]) ||
                 ((mode_q == MODE_REPNE) &&  flags_in[ZF_BIT]);
    end

    // Sequencer FSM: flush and reset both abandon the sequence without a writeback.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mode_q   <= MODE_NONE;
            early_q  <= 1'b0;
`ifdef REP_ADDR16_EN
            addr16_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (startReq) begin
                        count_q  <= count_in;
                        mode_q   <= rep_mode;
                        early_q  <= 1'b0;
`ifdef REP_ADDR16_EN
                        addr16_q <= addr16;
`endif
                        state_q  <= startZero ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!wb_stall) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iter_done) begin
                        count_q <= count_d;
                        if (decZero || zfTerm) begin
                            early_q <= zfTerm && !decZero;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from the registered state; only ex_stall sees the start request.
    always_comb begin
        iter_v           = (state_q == S_ISSUE);
        busy             = (state_q != S_IDLE);
        done             = (state_q == S_DONE);
        ld_count         = (state_q == S_DONE);
        terminated_early = (state_q == S_DONE) && early_q;
        count_out        = count_q;
        ex_stall         = busy || (startReq && !flush && CLR);
    end

endmodule

// File: tb/tb_rep_sequencer_ex.sv
// tb_rep_sequencer_ex: scoreboard bench for rep_sequencer_ex.
// Each started sequence pushes its predicted result; the done pulse pops and compares.
module tb_rep_sequencer_ex;

    localparam int CNT_W  = 32;
    localparam int ZF_BIT = 6;

    logic             clk = 1'b0;
    logic             clrN;
    logic             exV;
    logic             repStart;
    logic [1:0]       repMode;
    logic [CNT_W-1:0] countIn;
    logic             wbStall;
    logic             iterDone;
    logic [31:0]      flagsIn;
    logic             flush;
`ifdef REP_ADDR16_EN
    logic             addr16;
`endif
    logic             iterV;
    logic             busy;
    logic             exStall;
    logic [CNT_W-1:0] countOut;
    logic             ldCount;
    logic             done;
    logic             termEarly;

    typedef struct {
        logic [31:0] count;
        logic        early;
        int          iters;
        int          ivCycles;
        int          lat;
        int          startCyc;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   accCnt = 0;
    int   ivCnt = 0;
    int   stallRun = 0;

    rep_sequencer_ex #(.CNT_W(CNT_W), .ZF_BIT(ZF_BIT)) dut (
        .CLK              (clk),
        .CLR              (clrN),
        .EX_V             (exV),
        .rep_start        (repStart),
        .rep_mode         (repMode),
        .count_in         (countIn),
        .wb_stall         (wbStall),
        .iter_done        (iterDone),
        .flags_in         (flagsIn),
        .flush            (flush),
`ifdef REP_ADDR16_EN
        .addr16           (addr16),
`endif
        .iter_v           (iterV),
        .busy             (busy),
        .ex_stall         (exStall),
        .count_out        (countOut),
        .ld_count         (ldCount),
        .done             (done),
        .terminated_early (termEarly)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index used to measure start-to-done latency.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference behaviour of one sequence, including ZF stimulus the driver will apply.
    function automatic exp_t model(input logic [1:0] mode, input logic [31:0] cnt,
                                   input int zfAt, input int stallCyc, input logic a16);
        exp_t r;
        logic [31:0] c;
        int it;
        logic zf;
        logic zfT;
        logic z;
        c = cnt;
        it = 0;
        r.early = 1'b0;
        r.startCyc = 0;
        if (a16 ? (c[15:0] == 16'd0) : (c == 32'd0)) begin
            r.count = c;
            r.iters = 0;
            r.ivCycles = 0;
            r.lat = 1;
            return r;
        end
        for (int k = 0; k < 1000; k++) begin
            it++;
            if (a16) c = {c[31:16], c[15:0] - 16'd1};
            else     c = c - 32'd1;
            zf  = (it == zfAt) ? (mode == 2'b11) : (mode != 2'b11);
            zfT = ((mode == 2'b10) && !zf) || ((mode == 2'b11) && zf);
            z   = a16 ? (c[15:0] == 16'd0) : (c == 32'd0);
            if (z || zfT) begin
                r.early = zfT && !z;
                break;
            end
        end
        r.count = c;
        r.iters = it;
        r.ivCycles = it + stallCyc;
        r.lat = 1 + 2 * it + stallCyc;
        return r;
    endfunction

    // Monitor: tracks iteration traffic and ex_stall run length, scores each done pulse.
    always @(negedge clk) begin
        if (exStall) stallRun++;
        else         stallRun = 0;
        if (!busy) begin
            accCnt = 0;
            ivCnt = 0;
        end
        if (iterV) begin
            ivCnt++;
            if (!wbStall) accCnt++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", done, 1'b0);
            end else begin
                popped = sb.pop_front();
                checkOutput("countOut",  countOut, popped.count);
                checkOutput("termEarly", termEarly, popped.early);
                checkOutput("ldCount",   ldCount, 1'b1);
                checkOutput("accepted",  accCnt, popped.iters);
                checkOutput("iterVCyc",  ivCnt, popped.ivCycles);
                checkOutput("latency",   cycleCnt - popped.startCyc, popped.lat);
                checkOutput("exStallRun", stallRun, popped.lat + 1);
            end
        end
    end

    // Start a sequence and play the WB side; abortKind 0 = flush, 1 = reset at WAIT number abortAt.
    task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] cnt, input int zfAt,
                                 input int stallCyc, input int abortAt, input int abortKind,
                                 input logic a16);
        exp_t e;
        int iters;
        int stallLeft;
        bit ok;
        e = model(mode, cnt, zfAt, stallCyc, a16);
        @(posedge clk);
        #1;
        e.startCyc = cycleCnt;
        if (abortAt == 0) sb.push_back(e);
        exV = 1'b1;
        repStart = 1'b1;
        repMode = mode;
        countIn = cnt;
`ifdef REP_ADDR16_EN
        addr16 = a16;
`endif
        #1;
        checkOutput("exStallStart", exStall, 1'b1);
        @(posedge clk);
        #1;
        exV = 1'b0;
        repStart = 1'b0;
        countIn = $urandom;
`ifdef REP_ADDR16_EN
        addr16 = ~a16;
`endif
        iters = 0;
        stallLeft = stallCyc;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            wbStall = 1'b0;
            iterDone = 1'b0;
            flush = 1'b0;
            flagsIn = $urandom;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (iterV) begin
                if (stallLeft > 0) begin
                    wbStall = 1'b1;
                    iterDone = 1'b1;
                    stallLeft--;
                end
            end else if (busy) begin
                iters++;
                if (abortAt == iters) begin
                    if (abortKind == 0) begin
                        flush = 1'b1;
                        iterDone = 1'b1;
                    end else begin
                        clrN = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                    flush = 1'b0;
                    iterDone = 1'b0;
                    clrN = 1'b1;
                    checkOutput("abortBusy", busy, 1'b0);
                    checkOutput("abortDone", done, 1'b0);
                    checkOutput("abortLd", ldCount, 1'b0);
                    checkOutput("abortCount", countOut,
                                (abortKind == 0) ? (cnt - 32'(abortAt - 1)) : 32'd0);
                    for (int k = 0; k < 3; k++) begin
                        @(posedge clk);
                        #1;
                        checkOutput("abortQuiet", done | ldCount | busy, 1'b0);
                    end
                    return;
                end
                iterDone = 1'b1;
                flagsIn[ZF_BIT] = (iters == zfAt) ? (mode == 2'b11) : (mode != 2'b11);
            end
            @(posedge clk);
            #1;
        end
        wbStall = 1'b0;
        iterDone = 1'b0;
        if (!ok) begin
            checkOutput("timeout", done, 1'b1);
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        checkOutput("exStallAfter", exStall, 1'b0);
        checkOutput("busyAfter", busy, 1'b0);
    endtask

    // Request that must be ignored (no prefix or EX not valid).
    task automatic applyNoStart(input logic [1:0] mode, input logic valid);
        @(posedge clk);
        #1;
        exV = valid;
        repStart = 1'b1;
        repMode = mode;
        countIn = 32'd7;
        #1;
        checkOutput("noStartStall", exStall, 1'b0);
        @(posedge clk);
        #1;
        exV = 1'b0;
        repStart = 1'b0;
        checkOutput("noStartBusy", busy, 1'b0);
    endtask

    // Main sequence.
    initial begin
        clrN = 1'b0;
        exV = 1'b1;
        repStart = 1'b1;
        repMode = 2'b01;
        countIn = 32'd5;
        wbStall = 1'b0;
        iterDone = 1'b0;
        flagsIn = '0;
        flush = 1'b0;
`ifdef REP_ADDR16_EN
        addr16 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstIterV", iterV, 1'b0);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstLd", ldCount, 1'b0);
        checkOutput("rstCount", countOut, 32'd0);
        checkOutput("rstExStall", exStall, 1'b0);
        checkOutput("rstEarly", termEarly, 1'b0);
        exV = 1'b0;
        repStart = 1'b0;
        clrN = 1'b1;
        @(posedge clk);

        applyStimulus(2'b01, 32'd3, 0, 0, 0, 0, 1'b0);
        applyStimulus(2'b11, 32'd5, 2, 0, 0, 0, 1'b0);
        applyStimulus(2'b10, 32'd0, 0, 0, 0, 0, 1'b0);
        applyStimulus(2'b01, 32'd2, 0, 3, 0, 0, 1'b0);
        applyStimulus(2'b11, 32'd10, 0, 0, 3, 0, 1'b0);
        applyStimulus(2'b11, 32'd10, 0, 0, 2, 1, 1'b0);
        applyStimulus(2'b10, 32'd4, 3, 0, 0, 0, 1'b0);
        applyStimulus(2'b10, 32'd1, 1, 0, 0, 0, 1'b0);
        applyStimulus(2'b01, 32'd5, 2, 1, 0, 0, 1'b0);
        applyStimulus(2'b11, 32'h0001_0000, 1, 0, 0, 0, 1'b0);
        applyNoStart(2'b00, 1'b1);
        applyNoStart(2'b01, 1'b0);
`ifdef REP_ADDR16_EN
        applyStimulus(2'b01, 32'h0001_0000, 0, 0, 0, 0, 1'b1);
        applyStimulus(2'b01, 32'h0002_0001, 0, 0, 0, 0, 1'b1);
        applyStimulus(2'b11, 32'h0003_0000, 0, 0, 0, 0, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sbDrain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rep_sequencer_ex.md
Name: rep_sequencer_ex

Overview:
- Parametrised successor to the single-shot REPNE count path in execute.
- Iteratively issues string-op micro-iterations to WB under REP, REPE or REPNE control.
- Owns the ECX/CX count register, decrements it per completed iteration, evaluates termination, stalls execute while busy, and writes the final count back.
- Sits between execute operand select and the WB stage handshake.

Parameters:
CNT_W, 32, count register width in bits (must be >= 16)
ZF_BIT, 6, bit index of ZF in the flags word

Ports:
CLK  input  1  clock
CLR  input  1  synchronous active-low reset, sampled on rising CLK
EX_V  input  1  execute-stage valid
rep_start  input  1  string op with rep prefix present in EX
rep_mode  input  2  00 none, 01 REP, 10 REPE, 11 REPNE
count_in  input  CNT_W  initial count (forwarded ECX)
wb_stall  input  1  WB cannot accept an iteration this cycle
iter_done  input  1  WB reports one iteration complete
flags_in  input  32  flags produced by the completed iteration
flush  input  1  pipeline flush
iter_v  output  1  issue one iteration to WB
busy  output  1  state != IDLE
ex_stall  output  1  hold EX latches
count_out  output  CNT_W  current/final count
ld_count  output  1  write count_out to ECX (1-cycle pulse)
done  output  1  sequence complete (1-cycle pulse)
terminated_early  output  1  with done: ended on ZF condition with count != 0

Behaviour:
- Reset (CLR=0 at edge): state IDLE, count reg 0, all outputs 0. Reset mid-sequence aborts with no ld_count.
- States: IDLE, ISSUE, WAIT, DONE. Encoding is free; outputs are registered or decoded from state.
- IDLE:
  - If EX_V & rep_start & rep_mode!=00: latch count_in.
  - If count_in==0, go to DONE with no iteration; count unchanged, terminated_early=0.
  - Otherwise go to ISSUE.
  - ex_stall=1 combinationally in this start cycle.
  - rep_mode==00 or EX_V=0: no action, ex_stall=0.
- ISSUE: iter_v=1. If wb_stall, stay (iter_v held high). Otherwise the iteration is accepted and the next state is WAIT.
- WAIT:
  - iter_v=0. On iter_done: count <= count-1, modulo 2^CNT_W.
  - Terminate when any of the following holds: new count==0; REPE and flags_in[ZF_BIT]==0; REPNE and flags_in[ZF_BIT]==1.
  - Terminate goes to DONE; otherwise go back to ISSUE.
  - REP (01) ignores ZF.
- DONE: done=1, ld_count=1, count_out=final count. terminated_early=1 iff ZF terminated and count!=0. Next state is IDLE.
- ex_stall = busy (all non-IDLE states) | IDLE start condition. ex_stall is deasserted in the cycle after DONE.
- Minimum latency for count N>0 with no stalls: 1 + 2N cycles from start to the done pulse.
- flush: any state goes to IDLE next edge. Flush beats iter_done and rep_start in the same cycle. No ld_count or done is generated.
- rep_start while busy is ignored.
- iter_done outside WAIT is ignored.
- count_out mirrors the count register at all times.

Optional Feature:
REP_ADDR16_EN:
- Defined: adds input port addr16 (1 bit), sampled at start and latched for the whole sequence.
- When addr16=1, the zero check and the decrement use count[15:0] only. count[CNT_W-1:16] passes through unchanged to count_out. 16-bit wraparound stays in the low half.
- Undefined: port absent, full-width count always.

Test Plan:
- REP, count_in=3, no stalls, iter_done one cycle after each iter_v -> 3 iter_v pulses, done at cycle 7, count_out=0, ld_count=1, terminated_early=0.
- REPNE, count_in=5, ZF=1 on 2nd iter_done -> 2 iterations, done, count_out=3, terminated_early=1.
- REPE, count_in=0 -> no iter_v, done and ld_count one cycle after start, count_out=0, ex_stall high exactly 2 cycles.
- REP, count_in=2, wb_stall high 3 cycles in first ISSUE -> iter_v held 4 cycles, single acceptance, final count_out=0.
- REPNE, count_in=10, flush asserted in WAIT together with iter_done -> IDLE next cycle, no done, no ld_count, busy=0; CLR=0 mid-sequence gives the same result with count_out=0.
- REP_ADDR16_EN, addr16=1, count_in=0x0001_0000 -> immediate done (low half zero), count_out=0x0001_0000. With count_in=0x0002_0001: one iteration, count_out=0x0002_0000.
